exec_muldiv_seq: RTL
====================

// Module: exec_muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for MUL/DIV in the execute stage. It accepts a start
//  from decode/execute and iterates one shift-add (multiply) or restoring-
//  subtract (divide) step per cycle. While it runs it stalls the pipeline, then
//  presents a registered result for execute to mux onto ALU_result.
//  It sits beside the single-cycle ALU and owns its own adder. It is the only
//  multi-cycle execute resource.
// PARAMETERS
//  WIDTH   16  operand width; multiply gives a 2*WIDTH product.
//  CNT_W   5   iteration counter width; must satisfy 2**CNT_W > WIDTH.
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        request; sampled only in IDLE
//  op_div     in   1        0 = multiply, 1 = divide
//  opA        in   WIDTH    multiplicand / dividend (read1data)
//  opB        in   WIDTH    multiplier / divisor (read2data)
//  flush      in   1        pipeline squash; aborts the operation
//  stall      out  1        hold PC and upstream pipe registers
//  busy       out  1        state != IDLE
//  done       out  1        one-cycle pulse; results valid this cycle
//  result_lo  out  WIDTH    product[WIDTH-1:0] / quotient
//  result_hi  out  WIDTH    product[2W-1:WIDTH] / remainder
//  err        out  1        divide by zero; valid with done
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; cnt=0; result_lo/hi=0; err=0.
//    done, stall and busy are all 0. Reset mid-operation discards all work.
//  States:
//  - IDLE: if start & ~flush, latch opA, opB and op_div.
//    Then: DIV with opB==0 -> DONE, err=1, result_lo=all-1s, result_hi=opA.
//    Otherwise -> RUN with cnt=0 and err=0.
//  - RUN: one iteration per cycle; cnt increments.
//    Go to DONE when cnt==WIDTH-1 completes (exactly WIDTH iterations).
//    MUL: if mplier[0], acc=acc+mcand (WIDTH+1-bit sum, carry kept);
//      then shift {carry,acc,mplier} right by 1.
//    DIV: shift {rem,quot} left by 1; trial=rem-divisor (WIDTH+1 bits).
//      If trial>=0, rem=trial and quot[0]=1.
//  - DONE: done=1; result regs already updated; -> IDLE next cycle.
//  Latency: accept at cycle 0 -> RUN cycles 1..WIDTH -> done in cycle WIDTH+1
//    (cycle 17 at WIDTH=16). Divide by zero: done in cycle 1.
//  stall = (IDLE & start & ~flush) | RUN. stall is 0 in DONE so the pipeline
//    advances while the result is captured.
//  result_lo/hi/err hold their value until the next accepted start.
//  Between start and done they are undefined to consumers; the bench does not
//    check them.
//  start while RUN or DONE: ignored, not queued.
//  flush in any state: -> IDLE next edge; no done; result regs unchanged.
//    flush beats start in the same cycle.
//  Unsigned arithmetic only unless EXEC_MULDIV_SIGNED_EN is defined.
// CONFIGURATION
//  `define EXEC_MULDIV_SIGNED_EN: adds input port 'sign' (1 bit), sampled
//    with start.
//    - If sign=1, magnitudes of opA/opB are latched and the result signs are
//      recorded.
//    - RUN is followed by one FIX state that negates the product, quotient
//      and remainder as needed. Remainder takes the sign of the dividend.
//    - done moves to cycle WIDTH+2.
//    - With sign=0, FIX is skipped (latency WIDTH+1).
//  Undefined: no 'sign' port, no FIX state, unsigned only.
// TESTING
//  1. MUL 0x0003*0x0005 -> done at cycle 17, lo=0x000F, hi=0x0000;
//     stall=1 for cycles 0..16.
//  2. MUL 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001, err=0.
//  3. DIV 0x0064/0x0007 -> lo=0x000E, hi=0x0002; DIV 0x1234/0x0000 ->
//     done at cycle 1, err=1, lo=0xFFFF, hi=0x1234.
//  4. flush in RUN at cycle 8 -> IDLE at cycle 9, no done, prior results kept;
//     start pulse at cycle 5 (RUN) is ignored; new start completes normally.
//  5. rst_n low in cycle 10 of a MUL -> all outputs 0 at once; start 2*3 after
//     release -> lo=0x0006.
//  6. With EXEC_MULDIV_SIGNED_EN, sign=1:
//     MUL 0xFFFA*0x0003 -> hi=0xFFFF, lo=0xFFEE at cycle 18.
//     DIV 0xFFF9/0x0002 -> lo=0xFFFD, hi=0xFFFF.

Source files
------------

// File: rtl/exec_muldiv_seq.sv
// exec_muldiv_seq: multi-cycle shift-add multiply / restoring divide sequencer that stalls the pipe while it runs (signed mode: EXEC_MULDIV_SIGNED_EN)
module exec_muldiv_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
`ifdef EXEC_MULDIV_SIGNED_EN
  input  logic             sign,
`endif
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_r, lo_r, b_r, a_in, b_in, next_hi, next_lo;
  logic             div_r, sgn_in, fix_go;
  logic [WIDTH:0]   add_a, add_b, sum;
`ifdef EXEC_MULDIV_SIGNED_EN
  logic             sgn_r, neg_q, neg_r;
  assign sgn_in = sign;
  assign fix_go = sgn_r;
`else
  assign sgn_in = 1'b0;
  assign fix_go = 1'b0;
`endif
  // Operand magnitudes at accept; hi/lo hold acc/multiplier or remainder/quotient, b_r the fixed operand
  always_comb begin
    a_in    = (sgn_in && opA[WIDTH-1]) ? -opA : opA;
    b_in    = (sgn_in && opB[WIDTH-1]) ? -opB : opB;
    add_a   = div_r ? {hi_r, lo_r[WIDTH-1]} : {1'b0, hi_r};
    add_b   = div_r ? ~{1'b0, b_r} : (lo_r[0] ? {1'b0, b_r} : '0);
    sum     = add_a + add_b + {{WIDTH{1'b0}}, div_r};
    next_hi = div_r ? (sum[WIDTH] ? add_a[WIDTH-1:0] : sum[WIDTH-1:0]) : sum[WIDTH:1];
    next_lo = div_r ? {lo_r[WIDTH-2:0], ~sum[WIDTH]} : {sum[0], lo_r[WIDTH-1:1]};
  end
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  assign stall = (state == IDLE && start && !flush) || state == RUN || state == FIX;
  // Sequencer: accept, iterate WIDTH steps, optional sign fix, then one-cycle done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      b_r       <= '0;
      div_r     <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      err       <= 1'b0;
`ifdef EXEC_MULDIV_SIGNED_EN
      sgn_r     <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (start) begin
        div_r <= op_div;
        hi_r  <= '0;
        lo_r  <= op_div ? a_in : b_in;
        b_r   <= op_div ? b_in : a_in;
        cnt   <= '0;
        err   <= 1'b0;
`ifdef EXEC_MULDIV_SIGNED_EN
        sgn_r <= sign;
        neg_q <= sign && (opA[WIDTH-1] ^ opB[WIDTH-1]);
        neg_r <= sign && opA[WIDTH-1];
`endif
        if (op_div && opB == '0) begin
          state     <= DONE;
          err       <= 1'b1;
          result_lo <= '1;
          result_hi <= opA;
        end else begin
          state <= RUN;
        end
      end
    end else if (state == RUN) begin
      hi_r <= next_hi;
      lo_r <= next_lo;
      cnt  <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH - 1)) begin
        state <= fix_go ? FIX : DONE;
        if (!fix_go) begin
          result_lo <= next_lo;
          result_hi <= next_hi;
        end
      end
    end else if (state == FIX) begin
      state <= DONE;
`ifdef EXEC_MULDIV_SIGNED_EN
      if (div_r) begin
        result_lo <= neg_q ? -lo_r : lo_r;
        result_hi <= neg_r ? -hi_r : hi_r;
      end else begin
        {result_hi, result_lo} <= neg_q ? -{hi_r, lo_r} : {hi_r, lo_r};
      end
`endif
    end else begin
      state <= IDLE;
    end
  end
endmodule
